fix_mul_arb: RTL and testbench

- Round-robin arbiter and sequencer that shares one pipelined fixed-point multiplier among N_REQ requesters.
- The multiplier is the 16-bit signed unit with 3-cycle latency, full-precision product and saturated Q-format output.
- Each requester presents an operand pair with a level request and receives a one-cycle grant.
- The result comes back on a shared response bus, tagged with the requester id, a fixed number of cycles later.
- Sits between the per-channel compute engines and the single multiplier instance.

---
 rtl/fix_mul_arb.sv | 121 ++++++++++++
 tb/tb_fix_mul_arb.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fix_mul_arb.sv
// Round-robin arbiter that shares one pipelined fixed-point multiplier among N_REQ requesters.
// Operands are registered toward the multiplier; a {vld,id} tag pipe tags the returning product.
module fix_mul_arb #(
  parameter int WIDTH = 16,
  parameter int N_REQ = 4,
  parameter int LAT   = 3,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] req_in1,
  input  logic [N_REQ*WIDTH-1:0] req_in2,
  output logic [N_REQ-1:0]       gnt,
  output logic [WIDTH-1:0]       mul_in1,
  output logic [WIDTH-1:0]       mul_in2,
  input  logic [2*WIDTH-2:0]     mul_out,
  input  logic [WIDTH-1:0]       mul_out_round,
  output logic                   rsp_valid,
  output logic [ID_W-1:0]        rsp_id,
  output logic [2*WIDTH-2:0]     rsp_data,
  output logic [WIDTH-1:0]       rsp_round,
  output logic                   busy,
  output logic [15:0]            op_cnt
);

  logic [ID_W-1:0]           rr_ptr_r;
  logic                      gnt_vld_s;
  logic [ID_W-1:0]           gnt_idx_s;
  logic [WIDTH-1:0]          sel_a_s;
  logic [WIDTH-1:0]          sel_b_s;
  logic                      issue_vld_r;
  logic [ID_W-1:0]           issue_id_r;
  logic [LAT-1:0]            tag_vld_r;
  logic [LAT-1:0][ID_W-1:0]  tag_id_r;

  // Round-robin search: the requester closest after the last grant wins.
  always_comb begin
    int best_s;
    int dist_s;
    gnt_vld_s = 1'b0;
    gnt_idx_s = '0;
    best_s    = N_REQ;
    dist_s    = 0;
    if (en && rst_n) begin
      for (int i = 0; i < N_REQ; i++) begin
        dist_s = (i + 2 * N_REQ - 1 - int'(rr_ptr_r)) % N_REQ;
        if (req[i] && (dist_s < best_s)) begin
          best_s    = dist_s;
          gnt_vld_s = 1'b1;
          gnt_idx_s = ID_W'(i);
        end else begin
        end
      end
    end else begin
    end
  end

  // One-hot grant decode and operand selection for the winner.
  always_comb begin
    gnt     = '0;
    sel_a_s = '0;
    sel_b_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_vld_s && (gnt_idx_s == ID_W'(i))) begin
        gnt[i]  = 1'b1;
        sel_a_s = req_in1[i*WIDTH +: WIDTH];
        sel_b_s = req_in2[i*WIDTH +: WIDTH];
      end else begin
      end
    end
  end

  // Issue stage: capture operands, remember the winner, count grants.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_in1     <= '0;
      mul_in2     <= '0;
      issue_vld_r <= 1'b0;
      issue_id_r  <= '0;
      rr_ptr_r    <= ID_W'(N_REQ - 1);
      op_cnt      <= 16'h0000;
    end else if (gnt_vld_s) begin
      mul_in1     <= sel_a_s;
      mul_in2     <= sel_b_s;
      issue_vld_r <= 1'b1;
      issue_id_r  <= gnt_idx_s;
      rr_ptr_r    <= gnt_idx_s;
      if (op_cnt != 16'hFFFF) begin
        op_cnt <= op_cnt + 16'h0001;
      end else begin
        op_cnt <= op_cnt;
      end
    end else begin
      issue_vld_r <= 1'b0;
    end
  end

  // Tag pipe tracks the multiplier latency; it never stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld_r <= '0;
      tag_id_r  <= '0;
    end else begin
      tag_vld_r[0] <= issue_vld_r;
      tag_id_r[0]  <= issue_id_r;
      for (int s = 1; s < LAT; s++) begin
        tag_vld_r[s] <= tag_vld_r[s-1];
        tag_id_r[s]  <= tag_id_r[s-1];
      end
    end
  end

  assign rsp_valid = tag_vld_r[LAT-1];
  assign rsp_id    = tag_id_r[LAT-1];
  assign rsp_data  = mul_out;
  assign rsp_round = mul_out_round;
  assign busy      = issue_vld_r | (|tag_vld_r);

endmodule

// File: tb/tb_fix_mul_arb.sv
// Bench for fix_mul_arb: models the 3-cycle multiplier, predicts grants/responses from the
// round-robin rules with a queue of in-flight operations, plus directed vector tables.
module tb_fix_mul_arb;
  localparam int N = 4;
  localparam int W = 16;

  logic             clk, rst_n, en;
  logic [N-1:0]     req;
  logic [N*W-1:0]   req_in1, req_in2;
  logic [N-1:0]     gnt;
  logic [W-1:0]     mul_in1, mul_in2;
  logic [2*W-2:0]   mul_out;
  logic [W-1:0]     mul_out_round;
  logic             rsp_valid;
  logic [1:0]       rsp_id;
  logic [2*W-2:0]   rsp_data;
  logic [W-1:0]     rsp_round;
  logic             busy;
  logic [15:0]      op_cnt;

  fix_mul_arb #(.WIDTH(W), .N_REQ(N), .LAT(3)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .req_in1(req_in1), .req_in2(req_in2),
    .gnt(gnt), .mul_in1(mul_in1), .mul_in2(mul_in2), .mul_out(mul_out),
    .mul_out_round(mul_out_round), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_round(rsp_round), .busy(busy), .op_cnt(op_cnt)
  );

  typedef struct { int due; int id; logic signed [15:0] a; logic signed [15:0] b; } op_t;
  typedef struct { int cyc; int id; logic signed [30:0] data; logic signed [15:0] rnd; } rsp_t;
  typedef struct { int id; logic signed [15:0] a; logic signed [15:0] b;
                   logic signed [30:0] exp_data; logic signed [15:0] exp_round; } vec_t;

  op_t  rq[$];
  rsp_t log_q[$];
  int   last_id, cnt, cyc, errors, checks, busy_cycles;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] ref_round(input logic signed [31:0] p);
    logic signed [31:0] s;
    s = p >>> 8;
    if (s > 32767) return 16'h7fff;
    else if (s < -32768) return 16'h8000;
    else return s[15:0];
  endfunction

  // External multiplier: operands stable in cycle C give a product in cycle C+3.
  logic signed [31:0] p1, p2, p3;
  always @(posedge clk) begin
    p1 <= $signed(mul_in1) * $signed(mul_in2);
    p2 <= p1;
    p3 <= p2;
  end
  assign mul_out       = p3[30:0];
  assign mul_out_round = ref_round(p3);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_op(input int id, input logic signed [15:0] a, input logic signed [15:0] b);
    req_in1[id*W +: W] = a;
    req_in2[id*W +: W] = b;
  endtask

  // One clock cycle: entered at posedge+1 with inputs already driven.
  task automatic tick(input bit quiet);
    int exp_id;
    logic [N-1:0] sh, exp_gnt;
    logic signed [31:0] p;
    op_t o;
    rsp_t r;
    #3;
    exp_id = -1;
    if (en) begin
      for (int k = 1; k <= N; k++) begin
        int i;
        i  = (last_id + k) % N;
        sh = req >> i;
        if (exp_id < 0 && sh[0]) exp_id = i;
      end
    end
    exp_gnt = '0;
    if (exp_id >= 0) exp_gnt = N'(1) << exp_id;
    if (busy) busy_cycles++;
    if (!quiet) begin
      check("gnt", gnt, exp_gnt);
      check("busy", busy, (rq.size() > 0 && rq[0].due - 3 <= cyc));
      check("op_cnt", op_cnt, cnt);
      if (rq.size() > 0 && rq[0].due == cyc) begin
        p = rq[0].a * rq[0].b;
        check("rsp_valid", rsp_valid, 1);
        check("rsp_id", rsp_id, rq[0].id);
        check("rsp_data", rsp_data, p[30:0]);
        check("rsp_round", rsp_round, ref_round(p));
      end else begin
        check("rsp_valid_idle", rsp_valid, 0);
      end
      if (rsp_valid) begin
        r.cyc = cyc; r.id = rsp_id; r.data = rsp_data; r.rnd = rsp_round;
        log_q.push_back(r);
      end
    end
    if (rq.size() > 0 && rq[0].due == cyc) void'(rq.pop_front());
    if (exp_id >= 0) begin
      o.due = cyc + 4; o.id = exp_id;
      o.a = req_in1[exp_id*W +: W];
      o.b = req_in2[exp_id*W +: W];
      rq.push_back(o);
      last_id = exp_id;
      if (cnt < 65535) cnt++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vec[7];
    int c0;
    vec[0] = '{0,  16'sd1024,   16'sd8192, 31'sd8388608,     16'sh7fff};
    vec[1] = '{1, -16'sd1024,   16'sd8192, -31'sd8388608,    16'sh8000};
    vec[2] = '{2,  16'sd1023,   16'sd8195, 31'sd8383485,     16'sd32747};
    vec[3] = '{3,  16'sd300,    16'sd3,    31'sd900,         16'sd3};
    vec[4] = '{1, -16'sd300,    16'sd3,    -31'sd900,        -16'sd4};
    vec[5] = '{2,  16'sd32767,  16'sd32767, 31'sd1073676289, 16'sh7fff};
    vec[6] = '{3, -16'sd32768,  16'sd32767, -31'sd1073709056, 16'sh8000};

    errors = 0; checks = 0; cyc = 0; last_id = N - 1; cnt = 0; busy_cycles = 0;
    rst_n = 1'b0; en = 1'b1; req = '1; req_in1 = '0; req_in2 = '0;
    #12;
    check("rst_gnt", gnt, 0);
    check("rst_mul_in1", mul_in1, 0);
    check("rst_mul_in2", mul_in2, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_busy", busy, 0);
    check("rst_op_cnt", op_cnt, 0);
    req = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed single-requester products.
    for (int v = 0; v < 7; v++) begin
      log_q.delete();
      req = N'(1) << vec[v].id;
      set_op(vec[v].id, vec[v].a, vec[v].b);
      tick(0);
      req = '0;
      repeat (4) tick(0);
      check($sformatf("tv%0d_count", v), log_q.size(), 1);
      if (log_q.size() > 0) begin
        check($sformatf("tv%0d_id", v), log_q[0].id, vec[v].id);
        check($sformatf("tv%0d_data", v), log_q[0].data, vec[v].exp_data);
        check($sformatf("tv%0d_round", v), log_q[0].rnd, vec[v].exp_round);
      end
    end

    // All four requesting for 8 cycles.
    for (int i = 0; i < N; i++) set_op(i, 16'((i + 1) * 100), 16'sd3);
    log_q.delete();
    c0 = cnt;
    req = 4'b1111;
    repeat (8) tick(0);
    req = '0;
    repeat (4) tick(0);
    check("rr_rsp_count", log_q.size(), 8);
    for (int k = 0; k < log_q.size() && k < 8; k++) begin
      check($sformatf("rr_id%0d", k), log_q[k].id, k % 4);
      check($sformatf("rr_data%0d", k), log_q[k].data, 31'((k % 4 + 1) * 300));
    end
    check("rr_opcnt", op_cnt, c0 + 8);

    // Back-to-back saturating products from requesters 1 and 2.
    log_q.delete();
    req = 4'b0010; set_op(1, -16'sd1024, 16'sd8192); tick(0);
    req = 4'b0100; set_op(2, 16'sd1023, 16'sd8195);  tick(0);
    req = '0;
    repeat (4) tick(0);
    check("b2b_count", log_q.size(), 2);
    if (log_q.size() >= 2) begin
      check("b2b_id0", log_q[0].id, 1);
      check("b2b_data0", log_q[0].data, -31'sd8388608);
      check("b2b_round0", log_q[0].rnd, 16'sh8000);
      check("b2b_id1", log_q[1].id, 2);
      check("b2b_data1", log_q[1].data, 31'sd8383485);
      check("b2b_round1", log_q[1].rnd, 16'sd32747);
      check("b2b_adjacent", log_q[1].cyc, log_q[0].cyc + 1);
    end

    // en dropped after the first grant: drain only.
    log_q.delete();
    busy_cycles = 0;
    set_op(0, 16'sd7, 16'sd9); set_op(2, 16'sd11, 16'sd13);
    req = 4'b0101; en = 1'b1; tick(0);
    en = 1'b0;
    repeat (8) tick(0);
    req = '0; en = 1'b1; tick(0);
    check("drain_busy_cycles", busy_cycles, 4);
    check("drain_rsp_count", log_q.size(), 1);
    if (log_q.size() > 0) check("drain_rsp_id", log_q[0].id, 0);

    // Asynchronous reset with three operations in flight.
    for (int i = 0; i < N; i++) set_op(i, 16'(i + 21), 16'(i + 5));
    req = 4'b0111;
    repeat (3) tick(0);
    rst_n = 1'b0;
    #1;
    check("arst_gnt", gnt, 0);
    check("arst_mul_in1", mul_in1, 0);
    check("arst_mul_in2", mul_in2, 0);
    check("arst_rsp_valid", rsp_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_op_cnt", op_cnt, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc++;
    rq.delete(); log_q.delete(); last_id = N - 1; cnt = 0;
    req = '0;
    repeat (6) tick(0);
    check("post_reset_rsp", log_q.size(), 0);
    req = 4'b1001;
    #2;
    check("rr_restart", gnt, 4'b0001);
    tick(0);
    req = '0;
    repeat (4) tick(0);

    // Randomized traffic against the queue model.
    repeat (400) begin
      req = 4'($urandom_range(0, 15));
      en  = ($urandom_range(0, 7) != 0);
      for (int i = 0; i < N; i++) set_op(i, 16'($urandom), 16'($urandom));
      tick(0);
    end
    req = '0; en = 1'b1;
    repeat (5) tick(0);

    // Saturation of the operation counter.
    req = 4'b0001;
    set_op(0, 16'sd2, 16'sd3);
    while (cnt < 65534) tick(1);
    repeat (3) tick(0);
    req = '0;
    repeat (5) tick(0);
    check("opcnt_sat", op_cnt, 16'hFFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
